// File: rtl/d_sramlike_bridge.sv
// d_sramlike_bridge: converts the memory stage's SRAM-style data port into
// one sram-like bus transaction (req / addr_ok / data_ok) per instruction.
// The pipeline is stalled until the data phase completes. The returned read
// word is held until the global stall releases and the stage advances.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no transaction outstanding; request follows data_sram_en
// S_WAIT    | address phase accepted, waiting for data_ok
// S_DONE    | data phase finished, waiting for longest_stall to drop
module d_sramlike_bridge (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic        longest_stall,
    output logic        d_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic [31:0] data_rdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  wsize;

    // Request is only ever issued from IDLE, so nothing re-requests while a
    // transaction is outstanding or waiting to be consumed.
    assign data_req   = data_sram_en & (state_q == S_IDLE);
    assign d_stall    = data_sram_en & (state_q != S_DONE);
    assign data_wr    = |data_sram_wen;
    assign data_wdata = data_sram_wdata;

    // Store size from the byte-lane mask; unexpected masks fall back to word.
    always_comb begin
        unique case (data_sram_wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: wsize = 2'd0;
            4'b0011, 4'b1100:                   wsize = 2'd1;
            default:                            wsize = 2'd2;
        endcase
    end

    // Loads always fetch the full aligned word; mem_ctrl picks the lanes.
    always_comb begin
        if (data_wr) begin
            data_size = wsize;
            data_addr = data_sram_addr;
        end else begin
            data_size = 2'd2;
            data_addr = {data_sram_addr[31:2], 2'b00};
        end
    end

    // Next-state and read-word capture. A data_ok in IDLE counts only when
    // it completes the request accepted in that same cycle; a stray one is
    // ignored.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (data_req && data_addr_ok) begin
                    if (data_data_ok) begin
                        state_d = S_DONE;
                        rdata_d = data_rdata;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    state_d = S_DONE;
                    rdata_d = data_rdata;
                end
            end
            S_DONE: begin
                if (!longest_stall) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and read-word registers; reset abandons any bus transaction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    assign data_sram_rdata = rdata_q;

endmodule
